hazard_stall: RTL and testbench

- Pipeline interlock unit for the 5-stage MIPS32 datapath.
- Works alongside the forwarding selector: forwarding resolves hazards by bypass; this block resolves the ones bypass cannot.
- Those hazards are: load-use (one-cycle bubble), HI/LO reads behind a multi-cycle mult/div, and taken-branch flush.
- Drives the PC and IF/ID write enables and the IF/ID and ID/EX flushes. Tracks the mult/div busy window and keeps a saturating stall-cycle counter.

---
 rtl/hazard_stall_if.sv | 44 ++++
 rtl/hazard_stall.sv | 107 ++++++++++
 tb/tb_hazard_stall.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_if.sv
// Interlock bundle between the ID/EX pipeline view and the hazard unit.
// Master drives stage info, slave returns stall/flush control.
interface hazard_stall_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             rsUsed;
  logic             rtUsed;
  logic             hiloUseID;
  logic [4:0]       rdEX;
  logic             lwEX;
  logic             GPRWrEX;
  logic             mdStart;
  logic             mdOp;
  logic             branchEX;
  logic             PCWr;
  logic             IFIDWr;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             mdBusy;
  logic             mdDone;
  logic [CNT_W-1:0] stallCnt;

  modport master (
    output rs, rt, rsUsed, rtUsed,
    output hiloUseID, rdEX, lwEX,
    output GPRWrEX, mdStart, mdOp,
    output branchEX,
    input  PCWr, IFIDWr, IFIDFlush,
    input  IDEXFlush, mdBusy, mdDone,
    input  stallCnt
  );

  modport slave (
    input  rs, rt, rsUsed, rtUsed,
    input  hiloUseID, rdEX, lwEX,
    input  GPRWrEX, mdStart, mdOp,
    input  branchEX,
    output PCWr, IFIDWr, IFIDFlush,
    output IDEXFlush, mdBusy, mdDone,
    output stallCnt
  );
endinterface

// File: rtl/hazard_stall.sv
// MIPS32 interlock: load-use bubble, HI/LO wait on mult/div, branch flush.
// Tracks the mult/div busy window and a saturating stall-cycle count.
module hazard_stall #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_stall_if.slave bus
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [5:0] MULT_LD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LD  = 6'(DIV_CYCLES - 1);

  state_t           state;
  logic [5:0]       cnt;
  logic [5:0]       ld;
  logic             mdBusy;
  logic             mdDone;
  logic [CNT_W-1:0] stallCnt;

  logic rsHit;
  logic rtHit;
  logic loadUse;
  logic hiloStall;
  logic stall;

  assign rsHit = bus.rsUsed
               & (bus.rs == bus.rdEX);
  assign rtHit = bus.rtUsed
               & (bus.rt == bus.rdEX);

  assign loadUse = bus.lwEX
                 & bus.GPRWrEX
                 & (bus.rdEX != 5'd0)
                 & (rsHit | rtHit);

  assign hiloStall = bus.hiloUseID
                   & (mdBusy | bus.mdStart);

  // a taken branch squashes the stalled ID op
  assign stall = (loadUse | hiloStall)
               & ~bus.branchEX
               & ~rst;

  assign bus.PCWr      = ~stall;
  assign bus.IFIDWr    = ~stall;
  assign bus.IFIDFlush = bus.branchEX & ~rst;
  assign bus.IDEXFlush = (stall | bus.branchEX)
                       & ~rst;

  assign ld = bus.mdOp ? DIV_LD : MULT_LD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      mdBusy <= 1'b0;
      mdDone <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.mdStart) begin
            state  <= BUSY;
            cnt    <= ld;
            mdBusy <= 1'b1;
            mdDone <= (ld == 6'd0);
          end
        end
        BUSY: begin
          if (cnt == 6'd0) begin
            state  <= IDLE;
            mdBusy <= 1'b0;
            mdDone <= 1'b0;
          end else begin
            cnt    <= cnt - 6'd1;
            mdDone <= (cnt == 6'd1);
          end
        end
        default: begin
          state  <= IDLE;
          mdBusy <= 1'b0;
          mdDone <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign bus.mdBusy   = mdBusy;
  assign bus.mdDone   = mdDone;
  assign bus.stallCnt = stallCnt;

endmodule

// File: tb/tb_hazard_stall.sv
// Directed bench for hazard_stall with an expected-value queue.
// A second instance with a 4-bit counter covers saturation.
module tb_hazard_stall;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_stall_if #(.CNT_W(16)) bus ();
  hazard_stall_if #(.CNT_W(4))  bus4 ();

  hazard_stall #(
    .MULT_CYCLES(4),
    .DIV_CYCLES(32),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  hazard_stall #(
    .MULT_CYCLES(4),
    .DIV_CYCLES(32),
    .CNT_W(4)
  ) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4.slave)
  );

  typedef struct {
    logic       rst;
    logic       lw;
    logic       gpr;
    logic [4:0] rdEX;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsU;
    logic       rtU;
    logic       hilo;
    logic       mdS;
    logic       mdO;
    logic       br;
  } in_t;

  typedef struct {
    logic        pcWr;
    logic        ifidWr;
    logic        ifidFl;
    logic        idexFl;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  in_t  in;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  bit          act = 0;
  int          sCyc = 0;
  int          nCyc = 0;
  logic [15:0] mCnt = 0;
  logic [3:0]  mCnt4 = 0;

  task automatic clearIn();
    in = '{rst: 1'b0, lw: 1'b0, gpr: 1'b0,
           rdEX: 5'd0, rs: 5'd0, rt: 5'd0,
           rsU: 1'b0, rtU: 1'b0, hilo: 1'b0,
           mdS: 1'b0, mdO: 1'b0, br: 1'b0};
  endtask

  task automatic drive();
    rst            = in.rst;
    bus.lwEX       = in.lw;
    bus.GPRWrEX    = in.gpr;
    bus.rdEX       = in.rdEX;
    bus.rs         = in.rs;
    bus.rt         = in.rt;
    bus.rsUsed     = in.rsU;
    bus.rtUsed     = in.rtU;
    bus.hiloUseID  = in.hilo;
    bus.mdStart    = in.mdS;
    bus.mdOp       = in.mdO;
    bus.branchEX   = in.br;
    bus4.lwEX      = in.lw;
    bus4.GPRWrEX   = in.gpr;
    bus4.rdEX      = in.rdEX;
    bus4.rs        = in.rs;
    bus4.rt        = in.rt;
    bus4.rsUsed    = in.rsU;
    bus4.rtUsed    = in.rtU;
    bus4.hiloUseID = in.hilo;
    bus4.mdStart   = in.mdS;
    bus4.mdOp      = in.mdO;
    bus4.branchEX  = in.br;
  endtask

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  function automatic bit mBusy();
    return act && (cyc > sCyc) && (cyc <= sCyc + nCyc);
  endfunction

  task automatic step(input int n);
    exp_t e;
    exp_t g;
    bit   lu;
    bit   st;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive();
      lu = in.lw && in.gpr && (in.rdEX != 5'd0) &&
           ((in.rsU && in.rs == in.rdEX) ||
            (in.rtU && in.rt == in.rdEX));
      st = (lu || (in.hilo && (mBusy() || in.mdS)))
           && !in.br && !in.rst;
      e.pcWr   = !st;
      e.ifidWr = !st;
      e.ifidFl = in.br && !in.rst;
      e.idexFl = (st || in.br) && !in.rst;
      e.busy   = mBusy();
      e.done   = act && (cyc == sCyc + nCyc);
      e.cnt    = mCnt;
      e.cnt4   = mCnt4;
      q.push_back(e);
      #1;
      g = q.pop_front();
      chk("PCWr", 16'(bus.PCWr), 16'(g.pcWr));
      chk("IFIDWr", 16'(bus.IFIDWr), 16'(g.ifidWr));
      chk("IFIDFlush", 16'(bus.IFIDFlush), 16'(g.ifidFl));
      chk("IDEXFlush", 16'(bus.IDEXFlush), 16'(g.idexFl));
      chk("mdBusy", 16'(bus.mdBusy), 16'(g.busy));
      chk("mdDone", 16'(bus.mdDone), 16'(g.done));
      chk("stallCnt", bus.stallCnt, g.cnt);
      chk("stallCnt4", 16'(bus4.stallCnt), 16'(g.cnt4));
      @(posedge clk);
      if (in.rst) begin
        act   = 0;
        mCnt  = 0;
        mCnt4 = 0;
      end else begin
        if (st && mCnt != 16'hFFFF) mCnt++;
        if (st && mCnt4 != 4'hF) mCnt4++;
        if (in.mdS && !mBusy()) begin
          act  = 1;
          sCyc = cyc;
          nCyc = in.mdO ? 32 : 4;
        end
      end
      cyc++;
    end
  endtask

  initial begin
    clearIn();
    in.rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    step(1);
    clearIn();
    step(1);

    // load-use on rs, then clean cycle
    in.lw = 1; in.gpr = 1; in.rdEX = 5'd5;
    in.rs = 5'd5; in.rsU = 1;
    step(1);
    clearIn();
    step(1);

    // load-use on rt
    in.lw = 1; in.gpr = 1; in.rdEX = 5'd7;
    in.rt = 5'd7; in.rtU = 1; in.rs = 5'd7;
    step(1);
    clearIn();

    // $0 never stalls; unused rs ignored
    in.lw = 1; in.gpr = 1; in.rdEX = 5'd0;
    in.rs = 5'd0; in.rsU = 1;
    step(1);
    in.rdEX = 5'd5; in.rs = 5'd5; in.rsU = 0;
    step(1);
    in.rsU = 1; in.gpr = 0;
    step(1);
    clearIn();

    // taken branch beats load-use
    in.lw = 1; in.gpr = 1; in.rdEX = 5'd9;
    in.rs = 5'd9; in.rsU = 1; in.br = 1;
    step(1);
    clearIn();
    step(1);

    // divide with mflo held in ID
    in.mdS = 1; in.mdO = 1; in.hilo = 1;
    step(1);
    in.mdS = 0;
    step(33);
    clearIn();
    step(2);

    // reset mid-divide, then a mult window
    in.mdS = 1; in.mdO = 1;
    step(1);
    clearIn();
    step(9);
    in.rst = 1; in.lw = 1; in.gpr = 1;
    in.rdEX = 5'd3; in.rs = 5'd3; in.rsU = 1;
    in.hilo = 1; in.mdS = 1; in.br = 1;
    step(1);
    clearIn();
    step(1);
    in.mdS = 1; in.mdO = 0;
    step(1);
    in.mdS = 0;
    step(6);

    // stall streak for saturation
    in.lw = 1; in.gpr = 1; in.rdEX = 5'd12;
    in.rt = 5'd12; in.rtU = 1;
    step(20);
    clearIn();
    step(1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
